// File: rtl/obi_interconnect_pkg.sv
// Shared constants for the OBI system-bus interconnect.
package obi_interconnect_pkg;

  localparam int unsigned OBI_DATA_W              = 32;
  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/obi_interconnect_err_slave.sv
// Internal error responder: completes an unmapped access one cycle after its accept
// with zero read data. Shared by every per-master router.
module obi_interconnect_err_slave
  import obi_interconnect_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  err_accept_i,
  output logic                  rvalid_o,
  output logic [OBI_DATA_W-1:0] rdata_o
);

  logic err_rvalid_q;

  // One response per accepted miss; back-to-back misses give back-to-back responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_rvalid_q <= 1'b0;
    end else begin
      err_rvalid_q <= err_accept_i;
    end
  end

  assign rvalid_o = err_rvalid_q;
  assign rdata_o  = '0;

endmodule

// File: rtl/obi_interconnect_resp_router.sv
// Per-master request gating and in-order response routing. A new target is only
// selected once nothing is outstanding, so responses return in order without a FIFO.
module obi_interconnect_resp_router
  import obi_interconnect_pkg::*;
#(
  parameter int unsigned SLAVES          = 3,
  parameter int unsigned SLAVE_BITS      = (SLAVES == 1) ? 1 : $clog2(SLAVES),
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  master_req_i,
  output logic                  master_gnt_o,
  output logic                  master_rvalid_o,
  output logic [OBI_DATA_W-1:0] master_rdata_o,
  output logic                  master_err_o,
  input  logic [SLAVE_BITS-1:0] sel_i,
  input  logic                  hit_i,
  output logic [SLAVES-1:0]     slave_req_o,
  input  logic [SLAVES-1:0]     slave_gnt_i,
  input  logic [SLAVES-1:0]     slave_rvalid_i,
  input  logic [OBI_DATA_W-1:0] slave_rdata_i [SLAVES]
);

  localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [SLAVE_BITS-1:0] cur_sel;
  logic                  cur_err;

  logic                  sel_ok, cur_ok;
  logic                  allow, accept, resp;
  logic                  err_rvalid;
  logic [OBI_DATA_W-1:0] err_rdata;

  // Guard indexing against out-of-range selects when SLAVES is not a power of two.
  assign sel_ok = (32'(sel_i) < SLAVES);
  assign cur_ok = (32'(cur_sel) < SLAVES);

  // Request gating, grant and response selection.
  always_comb begin
    allow        = 1'b0;
    accept       = 1'b0;
    resp         = 1'b0;
    slave_req_o  = '0;
    master_gnt_o = 1'b0;
    cnt_d        = cnt;

    allow = master_req_i &
            ((cnt == '0) |
             ((cnt < CNT_MAX) & (hit_i == ~cur_err) & (~hit_i | (sel_i == cur_sel))));

    if (hit_i) begin
      if (sel_ok) begin
        slave_req_o[sel_i] = allow;
        master_gnt_o       = allow & slave_gnt_i[sel_i];
      end
    end else begin
      master_gnt_o = allow;
    end

    accept = master_req_i & master_gnt_o;

    if (cnt != '0) begin
      if (cur_err) begin
        resp = err_rvalid;
      end else if (cur_ok) begin
        resp = slave_rvalid_i[cur_sel];
      end
    end

    case ({accept, resp})
      2'b10:   cnt_d = cnt + CNT_ONE;
      2'b01:   cnt_d = cnt - CNT_ONE;
      default: cnt_d = cnt;
    endcase
  end

  // Outstanding count and current target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt     <= '0;
      cur_sel <= '0;
      cur_err <= 1'b0;
    end else begin
      cnt <= cnt_d;
      if (accept) begin
        cur_sel <= sel_i;
        cur_err <= ~hit_i;
      end
    end
  end

  obi_interconnect_err_slave u_err_slave (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .err_accept_i (accept & ~hit_i),
    .rvalid_o     (err_rvalid),
    .rdata_o      (err_rdata)
  );

  always_comb begin
    master_rdata_o = '0;
    if (cur_err) begin
      master_rdata_o = err_rdata;
    end else if (cur_ok) begin
      master_rdata_o = slave_rdata_i[cur_sel];
    end
  end

  assign master_rvalid_o = resp;
  assign master_err_o    = resp & cur_err;

endmodule

// File: tb/tb_obi_interconnect_resp_router.sv
// Directed cycle-by-cycle vectors for the per-master response router.
module tb_obi_interconnect_resp_router;

  localparam int unsigned SLAVES = 3;
  localparam int unsigned SB     = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          master_req_i;
  logic          master_gnt_o;
  logic          master_rvalid_o;
  logic [31:0]   master_rdata_o;
  logic          master_err_o;
  logic [SB-1:0] sel_i;
  logic          hit_i;
  logic [2:0]    slave_req_o;
  logic [2:0]    slave_gnt_i;
  logic [2:0]    slave_rvalid_i;
  logic [31:0]   slave_rdata_i [SLAVES];

  obi_interconnect_resp_router #(
    .SLAVES          (3),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .master_req_i    (master_req_i),
    .master_gnt_o    (master_gnt_o),
    .master_rvalid_o (master_rvalid_o),
    .master_rdata_o  (master_rdata_o),
    .master_err_o    (master_err_o),
    .sel_i           (sel_i),
    .hit_i           (hit_i),
    .slave_req_o     (slave_req_o),
    .slave_gnt_i     (slave_gnt_i),
    .slave_rvalid_i  (slave_rvalid_i),
    .slave_rdata_i   (slave_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Upstream decode must never hit on a nonexistent slave.
  always @(negedge clk_i) begin
    if (!rst_i && master_req_i && hit_i)
      assert (32'(sel_i) < SLAVES) else $error("illegal sel_i %0d with hit_i", sel_i);
  end

  typedef struct {
    logic        req;
    logic [1:0]  sel;
    logic        hit;
    logic [2:0]  sgnt;
    logic [2:0]  srv;
    logic [31:0] rdata;   // slave k drives rdata + k
    logic        e_gnt;
    logic [2:0]  e_sreq;
    logic        e_rv;
    logic        e_err;
    logic [31:0] e_rdata; // checked only when e_rv
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic req, logic [1:0] sel, logic hit, logic [2:0] sgnt,
                              logic [2:0] srv, logic [31:0] rdata, logic e_gnt,
                              logic [2:0] e_sreq, logic e_rv, logic e_err, logic [31:0] e_rdata);
    vec_t v;
    v.req = req; v.sel = sel; v.hit = hit; v.sgnt = sgnt; v.srv = srv; v.rdata = rdata;
    v.e_gnt = e_gnt; v.e_sreq = e_sreq; v.e_rv = e_rv; v.e_err = e_err; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    master_req_i   = v.req;
    sel_i          = v.sel;
    hit_i          = v.hit;
    slave_gnt_i    = v.sgnt;
    slave_rvalid_i = v.srv;
    for (int k = 0; k < int'(SLAVES); k++) slave_rdata_i[k] = v.rdata + 32'(k);
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    chk("gnt",    idx, 32'(master_gnt_o),    32'(v.e_gnt));
    chk("sreq",   idx, 32'(slave_req_o),     32'(v.e_sreq));
    chk("rvalid", idx, 32'(master_rvalid_o), 32'(v.e_rv));
    chk("err",    idx, 32'(master_err_o),    32'(v.e_err));
    if (v.e_rv) chk("rdata", idx, master_rdata_o, v.e_rdata);
  endtask

  initial begin
    //              req sel   hit sgnt    srv     rdata         gnt sreq    rv err rdata
    // single read to slave 1, response two cycles later
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 32'h0,        0, 3'b000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd1, 1, 3'b010, 3'b000, 32'h0,        1, 3'b010, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b000, 32'h0,        0, 3'b000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b010, 32'hDEADBEEE, 0, 3'b000, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b010, 32'h0,        0, 3'b000, 0, 0, 32'h0));
    // two accepts to slave 2 fill the window; no look-through at cnt==MAX
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b000, 32'h0,        1, 3'b100, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b000, 32'h0,        1, 3'b100, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b000, 32'h0,        0, 3'b000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b100, 32'h1000,     0, 3'b000, 1, 0, 32'h1002));
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b100, 32'h2000,     1, 3'b100, 1, 0, 32'h2002));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b100, 32'h3000,     0, 3'b000, 1, 0, 32'h3002));
    // slave 0 pending blocks a request to slave 2 until its response
    vecs.push_back(mk(1, 2'd0, 1, 3'b001, 3'b000, 32'h0,        1, 3'b001, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b000, 32'h0,        0, 3'b000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b001, 32'h40,       0, 3'b000, 1, 0, 32'h40));
    vecs.push_back(mk(1, 2'd2, 1, 3'b100, 3'b000, 32'h0,        1, 3'b100, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b010, 32'h0,        0, 3'b000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b100, 32'h50,       0, 3'b000, 1, 0, 32'h52));
    // consecutive misses give consecutive error responses; slave rvalids ignored
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 32'h0,        1, 3'b000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd0, 0, 3'b111, 3'b000, 32'h0,        1, 3'b000, 1, 1, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b111, 32'h77,       0, 3'b000, 1, 1, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b111, 32'h77,       0, 3'b000, 0, 0, 32'h0));
    // a hit cannot follow a pending miss until it completes
    vecs.push_back(mk(1, 2'd0, 0, 3'b000, 3'b000, 32'h0,        1, 3'b000, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd1, 1, 3'b010, 3'b000, 32'h0,        0, 3'b000, 1, 1, 32'h0));
    vecs.push_back(mk(1, 2'd1, 1, 3'b010, 3'b000, 32'h0,        1, 3'b010, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b010, 32'h10,       0, 3'b000, 1, 0, 32'h11));
    // ungranted request may retarget
    vecs.push_back(mk(1, 2'd0, 1, 3'b000, 3'b000, 32'h0,        0, 3'b001, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2'd1, 1, 3'b010, 3'b000, 32'h0,        1, 3'b010, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2'd0, 0, 3'b000, 3'b011, 32'h0,        0, 3'b000, 1, 0, 32'h1));

    // reset with slaves asserting rvalid
    rst_i = 1'b1;
    drive(mk(0, 2'd0, 0, 3'b111, 3'b111, 32'h5, 0, 3'b000, 0, 0, 32'h0));
    @(negedge clk_i);
    chk("rst_rvalid", -1, 32'(master_rvalid_o), 32'h0);
    chk("rst_gnt",    -1, 32'(master_gnt_o),    32'h0);
    chk("rst_sreq",   -1, 32'(slave_req_o),     32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    drive(mk(0, 2'd0, 0, 3'b000, 3'b000, 32'h0, 0, 3'b000, 0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk_i); #1;
      drive(vecs[i]);
      @(negedge clk_i);
      check_vec(vecs[i], i);
    end

    // reset mid-transaction drops the in-flight response
    @(posedge clk_i); #1;
    drive(mk(1, 2'd1, 1, 3'b010, 3'b000, 32'h0, 0, 3'b000, 0, 0, 32'h0));
    @(negedge clk_i);
    chk("mid_gnt", 100, 32'(master_gnt_o), 32'h1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    drive(mk(0, 2'd0, 0, 3'b000, 3'b010, 32'h9, 0, 3'b000, 0, 0, 32'h0));
    @(negedge clk_i);
    chk("mid_rst_rvalid", 101, 32'(master_rvalid_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("post_rst_rvalid", 102, 32'(master_rvalid_o), 32'h0);
    @(posedge clk_i); #1;
    drive(mk(1, 2'd0, 1, 3'b001, 3'b000, 32'h0, 0, 3'b000, 0, 0, 32'h0));
    @(negedge clk_i);
    chk("post_rst_gnt",  103, 32'(master_gnt_o), 32'h1);
    chk("post_rst_sreq", 103, 32'(slave_req_o),  32'h1);
    @(posedge clk_i); #1;
    drive(mk(0, 2'd0, 0, 3'b000, 3'b001, 32'hABC, 0, 3'b000, 0, 0, 32'h0));
    @(negedge clk_i);
    chk("post_rst_rvalid2", 104, 32'(master_rvalid_o), 32'h1);
    chk("post_rst_rdata",   104, master_rdata_o,       32'hABC);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
